// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding and default address/data widths for the arbiter and memory wrapper
package mem_arbiter_pkg;
  localparam int AW_DEF = 11;
  localparam int DW_DEF = 32;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles two requester ports (req/we/dlen/addr/wdata in, ack/rdata out), the memory port (m_we/m_dlen/m_addr/m_data out, m_q in) and busy/err_top status
interface mem_arbiter_if import mem_arbiter_pkg::*; #(parameter int AW = AW_DEF, parameter int DW = DW_DEF);
  logic req0, req1, we0, we1, dlen0, dlen1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic m_we, m_dlen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_q;
  logic busy, err_top;
  modport slave (
    input req0, req1, we0, we1, dlen0, dlen1, addr0, addr1, wdata0, wdata1, m_q,
    output ack0, ack1, rdata0, rdata1, m_we, m_dlen, m_addr, m_data, busy, err_top
  );
  modport master (
    output req0, req1, we0, we1, dlen0, dlen1, addr0, addr1, wdata0, wdata1, m_q,
    input ack0, ack1, rdata0, rdata1, m_we, m_dlen, m_addr, m_data, busy, err_top
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; ports clk, rst, req_i[1:0], en_i (commit grant) -> vld_o (any request), win_o (winner id)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       vld_o,
  output logic       win_o
);
  logic ptr_q;
  assign vld_o = |req_i;
  assign win_o = &req_i ? ~ptr_q : req_i[1];
  always_ff @(posedge clk)
    if (rst) ptr_q <= 1'b1;
    else if (en_i && vld_o) ptr_q <= win_o;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-cycle IDLE/ACCESS/RESP arbiter sharing one memory between two requesters; ports clk, rst, bus (mem_arbiter_if.slave)
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic win_q, we_q, dlen_q, ack0_q, ack1_q, err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
  logic vld, win, idle, acc, resp;
  assign idle = state_q == IDLE;
  assign acc  = state_q == ACCESS;
  assign resp = state_q == RESP;
  rr_arb2 u_arb (
    .clk(clk), .rst(rst), .req_i({bus.req1, bus.req0}), .en_i(idle), .vld_o(vld), .win_o(win)
  );
  always_comb begin
    state_d = state_q;
    state_d = idle ? (vld ? ACCESS : IDLE) : acc ? RESP : IDLE;
  end
  assign bus.m_we    = acc & we_q;
  assign bus.m_dlen  = acc & dlen_q;
  assign bus.m_addr  = acc ? addr_q : '0;
  assign bus.m_data  = acc ? wdata_q : '0;
  assign bus.busy    = !idle;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.err_top = err_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      dlen_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      ack0_q  <= resp & !win_q;
      ack1_q  <= resp & win_q;
      err_q   <= resp & dlen_q & (&addr_q);
      if (idle && vld) begin
        win_q   <= win;
        we_q    <= win ? bus.we1 : bus.we0;
        dlen_q  <= win ? bus.dlen1 : bus.dlen0;
        addr_q  <= win ? bus.addr1 : bus.addr0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (acc && !we_q && win_q) rdata1_q <= bus.m_q;
      if (acc && !we_q && !win_q) rdata0_q <= bus.m_q;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 11, word-address width of the shared 16-bit-word memory.
REQ-002 Parameter DW, default 32, request/response data width; two memory words per full access.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0/req1  in  1  access request from requester 0 (fetch) / 1 (data).
REQ-006 we0/we1  in  1  write (1) or read (0).
REQ-007 dlen0/dlen1  in  1  1 = 32-bit (two-word) access, 0 = 16-bit access.
REQ-008 addr0/addr1  in  AW  word address.
REQ-009 wdata0/wdata1  in  DW  write data; 16-bit writes use bits [15:0].
REQ-010 ack0/ack1  out  1  one-cycle completion pulse to the owning requester.
REQ-011 rdata0/rdata1  out  DW  read data, valid while ack asserted; held until next ack to that requester.
REQ-012 m_we, m_dlen  out  1  memory write enable / length.
REQ-013 m_addr  out  AW;  m_data  out  DW;  m_q  in  DW  (combinational memory read data).
REQ-014 busy  out  1  high while a transaction is in flight.
REQ-015 err_top  out  1  one-cycle pulse with ack when a dlen access targeted address all-ones.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; one transaction per 3 cycles, no overlap.
REQ-017 IDLE: if any req, choose winner, latch its we/dlen/addr/wdata and winner id, go ACCESS; else stay.
REQ-018 Both requesting: grant the one not granted last (round-robin pointer); pointer resets to favour requester 0.
REQ-019 Single requester: granted regardless of pointer; pointer updates to winner on every grant.
REQ-020 ACCESS: drive m_addr/m_dlen/m_data from latched fields, m_we = latched we; capture m_q into winner's rdata on read; go RESP.
REQ-021 m_we SHALL be high only in ACCESS; m_addr/m_dlen/m_data SHALL be 0 outside ACCESS.
REQ-022 RESP: pulse ack of winner only; ack of loser stays 0; go IDLE.
REQ-023 Latency: req sampled in IDLE at edge N -> ack high during cycle after edge N+2.
REQ-024 Read rdata: dlen=1 -> {word[addr], word[addr+1]}; dlen=0 -> {16'b0, word[addr]} as presented on m_q.
REQ-025 Top-address dlen (addr all-ones): transaction still issued (memory performs high-half-only write / zero-extended read); err_top pulses in RESP.
REQ-026 Requests latched at grant; deasserting req or changing fields after grant SHALL NOT affect the in-flight transaction.
REQ-027 Requester holding req after its ack is re-arbitrated in next IDLE normally (no double ack per request edge is implied; req is level).
REQ-028 Writes have no rdata update; rdata of writer retains previous value.
REQ-029 busy = 1 in ACCESS and RESP, 0 in IDLE.

Reset
REQ-030 rst high at any edge: state IDLE, pointer favours requester 0, all ack/err_top/busy/m_* outputs 0, rdata0/rdata1 0.
REQ-031 rst during ACCESS SHALL suppress m_we from the following cycle; in-flight transaction is dropped without ack.

Structure
REQ-032 Shared package holds FSM state encoding and AW/DW defaults, reused by the CPU top and memory wrapper.
REQ-033 One sub-module natural: rr_arb2 (2-way round-robin grant with pointer); all else inline.

Verification
REQ-034 Single read: memory words[0x010]=0xAAAA,[0x011]=0x5555; req0 read dlen=1 addr 0x010 -> ack0 2 cycles after grant, rdata0=0xAAAA5555.
REQ-035 Contention: req0 and req1 both held high from reset -> grants alternate 0,1,0,1; each ack every 3 cycles.
REQ-036 Write then read: req1 write dlen=0 addr 0x7F0 data 0x1234; then read -> rdata1=0x00001234; m_we high exactly one cycle.
REQ-037 Top address: req0 dlen=1 write 0xDEADBEEF to 0x7FF -> word[0x7FF]=0xDEAD, word[0x000] unchanged, err_top pulses with ack0.
REQ-038 Reset mid-ACCESS: assert rst in ACCESS -> no ack, m_we 0 next cycle, state IDLE, pointer reset.
REQ-039 Req withdrawal: req1 dropped the cycle after grant -> transaction completes, ack1 pulses once.
